// File: rtl/board_io_supervisor_if.sv
// rtl/board_io_supervisor_if.sv - board pin and core-facing signals of the IO supervisor
interface board_io_supervisor_if #(
  parameter int led_count   = 8,
  parameter int state_width = 5
);
  logic                   btn_reset_raw;
  logic                   btn_mode_raw;
  logic [state_width-1:0] cont_state;
  logic                   uart_rx_line;
  logic                   uart_tx_line;
  logic                   core_rst;
  logic [1:0]             mode;
  logic [led_count-1:0]   led;

  modport master (
    output btn_reset_raw, btn_mode_raw, cont_state, uart_rx_line, uart_tx_line,
    input  core_rst, mode, led
  );

  modport slave (
    input  btn_reset_raw, btn_mode_raw, cont_state, uart_rx_line, uart_tx_line,
    output core_rst, mode, led
  );
endinterface

// File: rtl/board_io_supervisor.sv
// rtl/board_io_supervisor.sv - button debounce, stretched core reset, activity/heartbeat LED bank
module board_io_supervisor #(
  parameter int led_count             = 8,
  parameter int state_width           = 5,
  parameter int debounce_cycles       = 120000,
  parameter int reset_hold_cycles     = 16,
  parameter int activity_hold_cycles  = 600000,
  parameter int heartbeat_half_cycles = 6000000
) (
  input logic                 clk,
  input logic                 rst,
  board_io_supervisor_if.slave io
);
  localparam int dw = $clog2(debounce_cycles + 1);
  localparam int aw = $clog2(activity_hold_cycles + 1);
  localparam int rw = (reset_hold_cycles > 1) ? $clog2(reset_hold_cycles) : 1;
  localparam int hw = (heartbeat_half_cycles > 1) ? $clog2(heartbeat_half_cycles) : 1;

  typedef enum logic [1:0] {st_hold, st_count, st_run} rst_state_t;

  // index 0 = reset button, 1 = mode button
  logic [1:0]    btn_s1, btn_s2, btn_lvl;
  logic [dw-1:0] db_cnt [2];

  // index 0 = rx line, 1 = tx line
  logic [1:0]    uart_s1, uart_s2, uart_prev;
  logic [aw-1:0] act_cnt [2];
  logic          rx_act, tx_act;

  rst_state_t    rst_state;
  logic [rw-1:0] hold_cnt;
  logic          core_rst_q;

  logic          mode_btn_prev;
  logic [1:0]    mode_q;

  logic [hw-1:0] hb_cnt;
  logic          hb;

  logic [led_count-1:0] led_q;

  assign rx_act = (act_cnt[0] != '0);
  assign tx_act = (act_cnt[1] != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s1    <= '0;
      btn_s2    <= '0;
      btn_lvl   <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      btn_s1 <= {io.btn_mode_raw, io.btn_reset_raw};
      btn_s2 <= btn_s1;
      for (int i = 0; i < 2; i++) begin
        if (btn_s2[i] == btn_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == dw'(debounce_cycles - 1)) begin
          btn_lvl[i] <= btn_s2[i];
          db_cnt[i]  <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      uart_s1    <= '1;
      uart_s2    <= '1;
      uart_prev  <= '1;
      act_cnt[0] <= '0;
      act_cnt[1] <= '0;
    end else begin
      uart_s1   <= {io.uart_tx_line, io.uart_rx_line};
      uart_s2   <= uart_s1;
      uart_prev <= uart_s2;
      for (int i = 0; i < 2; i++) begin
        // a start bit (falling edge) retriggers the hold window
        if (uart_prev[i] && !uart_s2[i]) begin
          act_cnt[i] <= aw'(activity_hold_cycles);
        end else if (act_cnt[i] != '0) begin
          act_cnt[i] <= act_cnt[i] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rst_state  <= st_hold;
      hold_cnt   <= '0;
      core_rst_q <= 1'b1;
    end else begin
      case (rst_state)
        st_hold: begin
          if (!btn_lvl[0]) begin
            rst_state <= st_count;
            hold_cnt  <= '0;
          end
        end
        st_count: begin
          if (btn_lvl[0]) begin
            rst_state <= st_hold;
          end else if (hold_cnt == rw'(reset_hold_cycles - 1)) begin
            rst_state  <= st_run;
            core_rst_q <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        st_run: begin
          if (btn_lvl[0]) begin
            rst_state  <= st_hold;
            core_rst_q <= 1'b1;
          end
        end
        default: begin
          rst_state  <= st_hold;
          core_rst_q <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_btn_prev <= 1'b0;
      mode_q        <= 2'd0;
      hb_cnt        <= '0;
      hb            <= 1'b0;
    end else begin
      mode_btn_prev <= btn_lvl[1];
      if (btn_lvl[1] && !mode_btn_prev) begin
        mode_q <= (mode_q == 2'd2) ? 2'd0 : mode_q + 2'd1;
      end
      if (hb_cnt == hw'(heartbeat_half_cycles - 1)) begin
        hb_cnt <= '0;
        hb     <= ~hb;
      end else begin
        hb_cnt <= hb_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q <= '0;
    end else begin
      case (mode_q)
        2'd0:    led_q <= led_count'(io.cont_state);
        2'd1:    led_q <= led_count'({core_rst_q, tx_act, rx_act, hb});
        2'd2:    led_q <= {hb, (led_count - 1)'(io.cont_state)};
        default: led_q <= '0;
      endcase
    end
  end

  assign io.core_rst = core_rst_q;
  assign io.mode     = mode_q;
  assign io.led      = led_q;
endmodule

// File: tb/tb_board_io_supervisor.sv
// tb/tb_board_io_supervisor.sv - directed and random checks of board_io_supervisor against a reference model
module tb_board_io_supervisor;
  localparam int led_count   = 8;
  localparam int state_width = 5;
  localparam int dbc         = 4;
  localparam int rhc         = 3;
  localparam int ahc         = 10;
  localparam int hbc         = 8;
  localparam int age_sat     = 1000;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  board_io_supervisor_if #(.led_count(led_count), .state_width(state_width)) io ();

  board_io_supervisor #(
    .led_count(led_count), .state_width(state_width), .debounce_cycles(dbc),
    .reset_hold_cycles(rhc), .activity_hold_cycles(ahc), .heartbeat_half_cycles(hbc)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (io)
  );

  // reference model: raw-input delay lines, debounce windows, ages since events
  bit [1:0] p_br, p_bm;
  bit [2:0] p_rx, p_tx;
  bit       q_r[$], q_m[$];
  bit       lv_r, lv_m, lv_m_prev;
  int       rise_n, age_rst, age_rx, age_tx, hb_edges;
  bit [7:0] m_led;

  function automatic bit window_all(bit q[$], bit v);
    foreach (q[k]) if (q[k] != v) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int sat_inc(int a);
    return (a < age_sat) ? a + 1 : a;
  endfunction

  task automatic model_step();
    bit hb, rx_a, tx_a, cr, fall_rx, fall_tx;
    if (rst) begin
      p_br = '0; p_bm = '0; p_rx = '1; p_tx = '1;
      q_r.delete(); q_m.delete();
      lv_r = 0; lv_m = 0; lv_m_prev = 0;
      rise_n = 0; age_rst = 0; age_rx = age_sat; age_tx = age_sat; hb_edges = 0;
      m_led = '0;
      return;
    end
    hb   = ((hb_edges / hbc) % 2) == 1;
    rx_a = age_rx < ahc;
    tx_a = age_tx < ahc;
    cr   = age_rst <= rhc;
    case (rise_n % 3)
      0:       m_led = 8'(io.cont_state);
      1:       m_led = {4'b0, cr, tx_a, rx_a, hb};
      default: m_led = {hb, 7'(io.cont_state)};
    endcase
    age_rst = lv_r ? 0 : sat_inc(age_rst);
    if (lv_m && !lv_m_prev) rise_n++;
    lv_m_prev = lv_m;
    q_r.push_back(p_br[1]);
    if (q_r.size() > dbc) void'(q_r.pop_front());
    if (q_r.size() == dbc && window_all(q_r, !lv_r)) lv_r = !lv_r;
    q_m.push_back(p_bm[1]);
    if (q_m.size() > dbc) void'(q_m.pop_front());
    if (q_m.size() == dbc && window_all(q_m, !lv_m)) lv_m = !lv_m;
    fall_rx = p_rx[2] && !p_rx[1];
    fall_tx = p_tx[2] && !p_tx[1];
    age_rx  = fall_rx ? 0 : sat_inc(age_rx);
    age_tx  = fall_tx ? 0 : sat_inc(age_tx);
    hb_edges++;
    p_br = {p_br[0], io.btn_reset_raw};
    p_bm = {p_bm[0], io.btn_mode_raw};
    p_rx = {p_rx[1:0], io.uart_rx_line};
    p_tx = {p_tx[1:0], io.uart_tx_line};
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("core_rst", io.core_rst, age_rst <= rhc);
    check("mode", io.mode, rise_n % 3);
    check("led", io.led, m_led);
  endtask

  task automatic press_mode();
    io.btn_mode_raw = 1'b1;
    repeat (8) tick();
    io.btn_mode_raw = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    int n, toggles, last_t;
    bit seen, seen_tx, prev;
    rst = 1'b1;
    io.btn_reset_raw = 1'b0;
    io.btn_mode_raw  = 1'b0;
    io.uart_rx_line  = 1'b1;
    io.uart_tx_line  = 1'b1;
    io.cont_state    = '0;

    // power-on stretch
    repeat (5) tick();
    check("rst_led", io.led, 0);
    check("rst_mode", io.mode, 0);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (io.core_rst) n++;
      else break;
    end
    check("pwr_stretch", n, rhc);

    // bounce rejection then held reset press
    repeat (4) tick();
    io.btn_reset_raw = 1'b1;
    repeat (3) tick();
    io.btn_reset_raw = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (io.core_rst) seen = 1;
    end
    check("glitch_rst", seen, 0);
    io.btn_reset_raw = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n++;
      if (io.core_rst) break;
    end
    check("press_latency", n, 2 + dbc + 1);
    repeat (20 - n) tick();
    io.btn_reset_raw = 1'b0;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      n++;
      if (!io.core_rst) break;
    end
    check("release_latency", n, 2 + dbc + 1 + rhc);

    // mode cycling
    io.cont_state = 5'h1B;
    repeat (2) tick();
    check("led_mode0", io.led, 8'h1B);
    press_mode();
    check("mode_seq0", io.mode, 1);
    press_mode();
    check("mode_seq1", io.mode, 2);
    check("led_mode2", io.led[6:0], 7'h1B);
    press_mode();
    check("mode_seq2", io.mode, 0);
    check("led_mode0b", io.led, 8'h1B);
    press_mode();
    check("mode_seq3", io.mode, 1);

    // activity single pulse and retrigger
    n = 0; seen_tx = 0;
    for (int i = 0; i < 30; i++) begin
      io.uart_rx_line = (i != 0);
      tick();
      if (io.led[1]) n++;
      if (io.led[2]) seen_tx = 1;
    end
    check("rx_hold", n, ahc);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      io.uart_rx_line = !(i == 0 || i == 5);
      tick();
      if (io.led[1]) n++;
      if (io.led[2]) seen_tx = 1;
    end
    check("rx_retrigger", n, 5 + ahc);
    check("tx_idle", seen_tx, 0);

    // heartbeat period
    prev = io.led[0]; toggles = 0; last_t = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (io.led[0] != prev) begin
        if (last_t >= 0) check("hb_period", i - last_t, hbc);
        last_t = i;
        prev = io.led[0];
        toggles++;
      end
    end
    check("hb_toggles", toggles, 40 / hbc);

    // mid-operation reset with activity pending in mode 2
    press_mode();
    check("mode_pre_rst", io.mode, 2);
    io.uart_rx_line = 1'b0;
    tick();
    io.uart_rx_line = 1'b1;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    check("midrst_mode", io.mode, 0);
    check("midrst_led", io.led, 0);
    check("midrst_core_rst", io.core_rst, 1);
    rst = 1'b0;

    // random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      io.cont_state = 5'($urandom);
      if (io.btn_reset_raw) io.btn_reset_raw = ($urandom_range(0, 3) != 0);
      else                  io.btn_reset_raw = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 4) == 0) io.btn_mode_raw = ~io.btn_mode_raw;
      if (io.uart_rx_line) io.uart_rx_line = ($urandom_range(0, 7) != 0);
      else                 io.uart_rx_line = ($urandom_range(0, 1) != 0);
      if (io.uart_tx_line) io.uart_tx_line = ($urandom_range(0, 9) != 0);
      else                 io.uart_tx_line = ($urandom_range(0, 1) != 0);
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
